// File: rtl/atpool_engine_if.sv
// Memory bus between the pooling engine and the layer-0/layer-1 scratch memories.
// The engine drives the strobes, addresses and write data. The memory returns read data.
interface atpool_engine_if #(
    parameter int DW = 13,
    parameter int AW = 12
);
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          csel;

    modport master (
        output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        input  cdata_rd
    );

    modport slave (
        input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        output cdata_rd
    );
endinterface

// File: rtl/atpool_engine.sv
// K x K max-pooling stage with optional ReLU and round-up-to-integer.
// Walks output windows row-major. Each window gets POOL^2 single-cycle reads
// from layer-0 followed by one write of the reduced value to layer-1.
//
// state | meaning
// IDLE  | waiting for ready; busy low
// RD    | streaming the POOL^2 reads of the current window, tracking the max
// WR    | writing the post-processed max; then next window or back to IDLE
module atpool_engine #(
    parameter int DW       = 13,
    parameter int FRAC     = 4,
    parameter int IMG_W    = 64,
    parameter int POOL     = 2,
    parameter int AW       = 12,
    parameter int RELU     = 1,
    parameter int ROUND_UP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ready,
    output logic            busy,
    atpool_engine_if.master mem
);

    localparam int NW = IMG_W / POOL;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam int PW = $clog2(POOL);

    localparam logic [CW-1:0] LAST_WIN  = CW'(NW - 1);
    localparam logic [PW-1:0] LAST_K    = PW'(POOL - 1);
    localparam logic [DW:0]   RND_ADD   = (DW+1)'((2 ** FRAC) - 1);
    localparam logic [DW-1:0] FRAC_MASK = ~DW'((2 ** FRAC) - 1);
    localparam logic [DW-1:0] SAT_MAX   = DW'((2 ** (DW - 1)) - (2 ** FRAC));

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        win_r_q, win_r_d;
    logic [CW-1:0]        win_c_q, win_c_d;
    logic [PW-1:0]        ki_q, ki_d;
    logic [PW-1:0]        kj_q, kj_d;
    logic signed [DW-1:0] max_q, max_d;
    logic signed [DW-1:0] max_new;

    logic          busy_q, busy_d;
    logic          crd_q, crd_d;
    logic          cwr_q, cwr_d;
    logic          csel_q, csel_d;
    logic [AW-1:0] caddr_rd_q, caddr_rd_d;
    logic [AW-1:0] caddr_wr_q, caddr_wr_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;

    // Source address of element (i,j) inside output window (r,c).
    function automatic logic [AW-1:0] rd_addr(input logic [CW-1:0] r,
                                              input logic [CW-1:0] c,
                                              input logic [PW-1:0] i,
                                              input logic [PW-1:0] j);
        return AW'((AW'(r) * AW'(POOL) + AW'(i)) * AW'(IMG_W)
                   + AW'(c) * AW'(POOL) + AW'(j));
    endfunction

    // Destination address of output window (r,c).
    function automatic logic [AW-1:0] wr_addr(input logic [CW-1:0] r,
                                              input logic [CW-1:0] c);
        return AW'(AW'(r) * AW'(NW) + AW'(c));
    endfunction

    // ReLU first, then ceiling to an integer. The only overflow possible is
    // upward past the positive limit, which saturates to the largest integer.
    function automatic logic [DW-1:0] post_proc(input logic signed [DW-1:0] v);
        logic signed [DW-1:0] t;
        logic [DW:0]          s;
        t = v;
        s = '0;
        if (RELU != 0 && t[DW-1]) begin
            t = '0;
        end
        if (ROUND_UP != 0) begin
            s = {t[DW-1], t} + RND_ADD;
            if (s[DW] != s[DW-1]) begin
                t = SAT_MAX;
            end else begin
                t = s[DW-1:0] & FRAC_MASK;
            end
        end
        return t;
    endfunction

    // Running max: the first element of a window loads, later ones compare signed.
    always_comb begin
        max_new = max_q;
        if (ki_q == '0 && kj_q == '0) begin
            max_new = $signed(mem.cdata_rd);
        end else if ($signed(mem.cdata_rd) > max_q) begin
            max_new = $signed(mem.cdata_rd);
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d    = state_q;
        win_r_d    = win_r_q;
        win_c_d    = win_c_q;
        ki_d       = ki_q;
        kj_d       = kj_q;
        max_d      = max_q;
        busy_d     = busy_q;
        crd_d      = crd_q;
        cwr_d      = cwr_q;
        csel_d     = csel_q;
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;

        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    state_d    = S_RD;
                    busy_d     = 1'b1;
                    crd_d      = 1'b1;
                    cwr_d      = 1'b0;
                    csel_d     = 1'b0;
                    win_r_d    = '0;
                    win_c_d    = '0;
                    ki_d       = '0;
                    kj_d       = '0;
                    caddr_rd_d = '0;
                end
            end

            S_RD: begin
                max_d = max_new;
                if (ki_q == LAST_K && kj_q == LAST_K) begin
                    state_d    = S_WR;
                    crd_d      = 1'b0;
                    cwr_d      = 1'b1;
                    csel_d     = 1'b1;
                    caddr_wr_d = wr_addr(win_r_q, win_c_q);
                    cdata_wr_d = post_proc(max_new);
                end else begin
                    if (kj_q == LAST_K) begin
                        kj_d = '0;
                        ki_d = ki_q + PW'(1);
                    end else begin
                        kj_d = kj_q + PW'(1);
                    end
                    caddr_rd_d = rd_addr(win_r_q, win_c_q, ki_d, kj_d);
                end
            end

            S_WR: begin
                cwr_d  = 1'b0;
                csel_d = 1'b0;
                ki_d   = '0;
                kj_d   = '0;
                if (win_r_q == LAST_WIN && win_c_q == LAST_WIN) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    crd_d   = 1'b0;
                    win_r_d = '0;
                    win_c_d = '0;
                end else begin
                    state_d = S_RD;
                    crd_d   = 1'b1;
                    if (win_c_q == LAST_WIN) begin
                        win_c_d = '0;
                        win_r_d = win_r_q + CW'(1);
                    end else begin
                        win_c_d = win_c_q + CW'(1);
                    end
                    caddr_rd_d = rd_addr(win_r_d, win_c_d, '0, '0);
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                crd_d   = 1'b0;
                cwr_d   = 1'b0;
                csel_d  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset discards any partial window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            win_r_q    <= '0;
            win_c_q    <= '0;
            ki_q       <= '0;
            kj_q       <= '0;
            max_q      <= '0;
            busy_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= 1'b0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
        end else begin
            state_q    <= state_d;
            win_r_q    <= win_r_d;
            win_c_q    <= win_c_d;
            ki_q       <= ki_d;
            kj_q       <= kj_d;
            max_q      <= max_d;
            busy_q     <= busy_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            csel_q     <= csel_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
        end
    end

    assign busy         = busy_q;
    assign mem.crd      = crd_q;
    assign mem.cwr      = cwr_q;
    assign mem.csel     = csel_q;
    assign mem.caddr_rd = caddr_rd_q;
    assign mem.caddr_wr = caddr_wr_q;
    assign mem.cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_atpool_engine.sv
// Bench for atpool_engine: four parameterisations sharing one clock, each with a
// behavioural memory and a window-level reference model of max-pool + post-processing.
module tb_atpool_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ready_v;
    logic [3:0] busy_v;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;
    int bcnt[4];
    int wr_cnt[4];
    int last_wr[4];
    int rd_log0[$];
    int rd_log3[$];

    logic [12:0] mm   [0:4095];
    logic [12:0] mem0 [0:4095];
    logic [12:0] mem1 [0:15];
    logic [12:0] mem2 [0:3];
    logic [12:0] mem3 [0:255];
    logic [12:0] out0 [0:1023];
    logic [12:0] out1 [0:3];
    logic [12:0] out2 [0:0];
    logic [12:0] out3 [0:15];

    always #5 clk = ~clk;

    atpool_engine_if #(.DW(13), .AW(12)) bus0 ();
    atpool_engine_if #(.DW(13), .AW(4))  bus1 ();
    atpool_engine_if #(.DW(13), .AW(2))  bus2 ();
    atpool_engine_if #(.DW(13), .AW(8))  bus3 ();

    atpool_engine dut0 (.clk(clk), .reset(reset), .ready(ready_v[0]), .busy(busy_v[0]), .mem(bus0));

    atpool_engine #(.IMG_W(4), .POOL(2), .AW(4), .RELU(0), .ROUND_UP(1)) dut1 (
        .clk(clk), .reset(reset), .ready(ready_v[1]), .busy(busy_v[1]), .mem(bus1));

    atpool_engine #(.IMG_W(2), .POOL(2), .AW(2), .RELU(1), .ROUND_UP(0)) dut2 (
        .clk(clk), .reset(reset), .ready(ready_v[2]), .busy(busy_v[2]), .mem(bus2));

    atpool_engine #(.IMG_W(16), .POOL(4), .AW(8), .RELU(1), .ROUND_UP(1)) dut3 (
        .clk(clk), .reset(reset), .ready(ready_v[3]), .busy(busy_v[3]), .mem(bus3));

    assign bus0.cdata_rd = mem0[bus0.caddr_rd];
    assign bus1.cdata_rd = mem1[bus1.caddr_rd];
    assign bus2.cdata_rd = mem2[bus2.caddr_rd];
    assign bus3.cdata_rd = mem3[bus3.caddr_rd];

    // Bus monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus0.crd) rd_log0.push_back(int'(bus0.caddr_rd));
        if (bus0.cwr) begin
            out0[int'(bus0.caddr_wr)] = bus0.cdata_wr;
            wr_cnt[0]++;
            last_wr[0] = int'(bus0.caddr_wr);
        end
        if (bus3.crd) rd_log3.push_back(int'(bus3.caddr_rd));
        if (bus1.cwr) begin out1[int'(bus1.caddr_wr)] = bus1.cdata_wr; wr_cnt[1]++; end
        if (bus2.cwr) begin out2[0] = bus2.cdata_wr; wr_cnt[2]++; end
        if (bus3.cwr) begin
            out3[int'(bus3.caddr_wr)] = bus3.cdata_wr;
            wr_cnt[3]++;
            last_wr[3] = int'(bus3.caddr_wr);
        end
        if ((bus0.crd && bus0.cwr) || (bus1.crd && bus1.cwr) ||
            (bus2.crd && bus2.cwr) || (bus3.crd && bus3.cwr)) overlap++;
        for (int k = 0; k < 4; k++) if (busy_v[k]) bcnt[k]++;
    end

    function automatic int w_of(input int k);
        case (k) 0: return 64; 1: return 4; 2: return 2; default: return 16; endcase
    endfunction
    function automatic int p_of(input int k);
        return (k == 3) ? 4 : 2;
    endfunction

    // Reference: max over the window as integers, then ReLU, then ceiling to a multiple of 16.
    function automatic logic [12:0] model_win(input int k, input int r, input int c);
        int w, p, mx, v, a;
        w = w_of(k);
        p = p_of(k);
        mx = -100000;
        for (int i = 0; i < p; i++)
            for (int j = 0; j < p; j++) begin
                a = (r * p + i) * w + c * p + j;
                v = int'(mm[a]);
                if (v >= 4096) v = v - 8192;
                if (v > mx) mx = v;
            end
        if (k != 1 && mx < 0) mx = 0;
        if (k != 2) begin
            if (mx >= 0) mx = ((mx + 15) / 16) * 16;
            else         mx = (mx / 16) * 16;
            if (mx > 4095) mx = 4080;
        end
        return 13'(mx);
    endfunction

    function automatic logic [12:0] get_out(input int k, input int idx);
        case (k)
            0: return out0[idx];
            1: return out1[idx];
            2: return out2[idx];
            default: return out3[idx];
        endcase
    endfunction

    function automatic int count_mismatch(input int k);
        int n, nw;
        n = 0;
        nw = w_of(k) / p_of(k);
        for (int r = 0; r < nw; r++)
            for (int c = 0; c < nw; c++)
                if (get_out(k, r * nw + c) !== model_win(k, r, c)) n++;
        return n;
    endfunction

    task automatic load_mem(input int k);
        int w;
        w = w_of(k);
        for (int a = 0; a < w * w; a++)
            case (k)
                0: mem0[a] = mm[a];
                1: mem1[a] = mm[a];
                2: mem2[a] = mm[a];
                default: mem3[a] = mm[a];
            endcase
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 4; k++) begin bcnt[k] = 0; wr_cnt[k] = 0; last_wr[k] = -1; end
        rd_log0.delete();
        rd_log3.delete();
        for (int i = 0; i < 1024; i++) out0[i] = 13'h1555;
        for (int i = 0; i < 4; i++) out1[i] = 13'h1555;
        out2[0] = 13'h1555;
        for (int i = 0; i < 16; i++) out3[i] = 13'h1555;
    endtask

    task automatic fill_random(input int n);
        for (int a = 0; a < n; a++) mm[a] = 13'($urandom_range(0, 8191));
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (busy_v[k] && n < 20000) begin @(negedge clk); n++; end
        if (busy_v[k]) begin
            checks++; failures++;
            $display("FAIL timeout dut%0d busy still high after %0d cycles", k, n);
        end
    endtask

    task automatic run_dut(input int k);
        @(negedge clk); ready_v[k] = 1'b1;
        @(negedge clk); ready_v[k] = 1'b0;
        wait_idle(k);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ready_v = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_v[0], bus0.crd, bus0.cwr, bus0.csel, bus0.caddr_rd, bus0.caddr_wr, bus0.cdata_wr} !== '0) begin
            failures++;
            $display("FAIL reset_dut0 got busy=%b crd=%b cwr=%b csel=%b ard=%0d awr=%0d dwr=%h exp all zero",
                     busy_v[0], bus0.crd, bus0.cwr, bus0.csel, bus0.caddr_rd, bus0.caddr_wr, bus0.cdata_wr);
        end
        checks++;
        if ({busy_v[3], bus3.crd, bus3.cwr, bus3.csel, bus3.caddr_rd, bus3.caddr_wr, bus3.cdata_wr} !== '0) begin
            failures++;
            $display("FAIL reset_dut3 got busy=%b crd=%b cwr=%b exp all zero", busy_v[3], bus3.crd, bus3.cwr);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        int exp_rd[4] = '{0, 1, 64, 65};
        for (int a = 0; a < 4096; a++) mm[a] = 13'(a);
        load_mem(0);
        clear_stats();
        run_dut(0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_log0.size() <= i || rd_log0[i] !== exp_rd[i]) begin
                failures++;
                $display("FAIL ramp_read_order idx=%0d got=%0d exp=%0d", i,
                         (rd_log0.size() > i) ? rd_log0[i] : -1, exp_rd[i]);
            end
        end
        checks++;
        if (out0[0] !== 13'h0050) begin failures++; $display("FAIL ramp_win0 got=%h exp=0050", out0[0]); end
        checks++;
        if (last_wr[0] !== 1023) begin failures++; $display("FAIL ramp_last_wr got=%0d exp=1023", last_wr[0]); end
        checks++;
        if (rd_log0.size() !== 4096 || rd_log0[rd_log0.size()-1] !== 4095) begin
            failures++;
            $display("FAIL ramp_reads got_count=%0d exp_count=4096 (last must be 4095)", rd_log0.size());
        end
        checks++;
        if (wr_cnt[0] !== 1024) begin failures++; $display("FAIL ramp_wr_count got=%0d exp=1024", wr_cnt[0]); end
        checks++;
        if (bcnt[0] !== 5120) begin failures++; $display("FAIL ramp_busy_len got=%0d exp=5120", bcnt[0]); end
        checks++;
        if (count_mismatch(0) !== 0) begin
            failures++; $display("FAIL ramp_model got_mismatches=%0d exp=0", count_mismatch(0));
        end
    endtask

    task automatic test_relu_saturate();
        int nz;
        for (int a = 0; a < 4096; a++) mm[a] = 13'h1FF0;
        mm[0] = 13'h0FF1; mm[1] = 13'h0010; mm[64] = 13'h0020; mm[65] = 13'h0000;
        load_mem(0);
        clear_stats();
        run_dut(0);
        checks++;
        if (out0[0] !== 13'h0FF0) begin failures++; $display("FAIL sat_win0 got=%h exp=0ff0", out0[0]); end
        nz = 0;
        for (int i = 1; i < 1024; i++) if (out0[i] !== 13'h0000) nz++;
        checks++;
        if (nz !== 0) begin failures++; $display("FAIL relu_neg got_nonzero=%0d exp=0", nz); end
        mm[0] = 13'h0FF1; mm[1] = 13'h0010; mm[2] = 13'h0020; mm[3] = 13'h0000;
        load_mem(2);
        run_dut(2);
        checks++;
        if (out2[0] !== 13'h0FF1) begin failures++; $display("FAIL noround_win got=%h exp=0ff1", out2[0]); end
    endtask

    task automatic test_round_negative();
        int bad;
        for (int a = 0; a < 16; a++) mm[a] = 13'h1FF0;
        load_mem(1);
        clear_stats();
        run_dut(1);
        bad = 0;
        for (int i = 0; i < 4; i++) if (out1[i] !== 13'h1FF0) bad++;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL round_neg got_bad=%0d exp=0 (out0=%h)", bad, out1[0]); end
        fill_random(16);
        load_mem(1);
        clear_stats();
        run_dut(1);
        checks++;
        if (count_mismatch(1) !== 0) begin
            failures++; $display("FAIL norelu_model got_mismatches=%0d exp=0", count_mismatch(1));
        end
        checks++;
        if (bcnt[1] !== 20) begin failures++; $display("FAIL norelu_busy_len got=%0d exp=20", bcnt[1]); end
    endtask

    task automatic test_reset_midrun();
        fill_random(4096);
        load_mem(0);
        clear_stats();
        @(negedge clk); ready_v[0] = 1'b1;
        @(negedge clk); ready_v[0] = 1'b0;
        repeat (98) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_v[0], bus0.crd, bus0.cwr, bus0.csel, bus0.caddr_rd, bus0.caddr_wr, bus0.cdata_wr} !== '0) begin
            failures++;
            $display("FAIL midrun_reset got busy=%b crd=%b cwr=%b ard=%0d awr=%0d exp all zero",
                     busy_v[0], bus0.crd, bus0.cwr, bus0.caddr_rd, bus0.caddr_wr);
        end
        reset = 1'b0;
        clear_stats();
        run_dut(0);
        checks++;
        if (count_mismatch(0) !== 0) begin
            failures++; $display("FAIL rerun_model got_mismatches=%0d exp=0", count_mismatch(0));
        end
        checks++;
        if (bcnt[0] !== 5120) begin failures++; $display("FAIL rerun_busy_len got=%0d exp=5120", bcnt[0]); end
    endtask

    task automatic test_pool4();
        fill_random(256);
        load_mem(3);
        clear_stats();
        run_dut(3);
        checks++;
        if (count_mismatch(3) !== 0) begin
            failures++; $display("FAIL pool4_model got_mismatches=%0d exp=0", count_mismatch(3));
        end
        checks++;
        if (bcnt[3] !== 272) begin failures++; $display("FAIL pool4_busy_len got=%0d exp=272", bcnt[3]); end
        checks++;
        if (rd_log3.size() !== 256 || rd_log3[96] !== 72 || rd_log3[111] !== 123) begin
            failures++;
            $display("FAIL pool4_win12_addr got_count=%0d first=%0d last=%0d exp 256/72/123", rd_log3.size(),
                     (rd_log3.size() > 96) ? rd_log3[96] : -1, (rd_log3.size() > 111) ? rd_log3[111] : -1);
        end
        checks++;
        if (last_wr[3] !== 15 || wr_cnt[3] !== 16) begin
            failures++; $display("FAIL pool4_writes got_last=%0d got_count=%0d exp 15/16", last_wr[3], wr_cnt[3]);
        end
    endtask

    task automatic test_ready_held();
        int n, len1, gap, len2;
        fill_random(4096);
        load_mem(0);
        clear_stats();
        @(negedge clk); ready_v[0] = 1'b1;
        n = 0;
        while (!busy_v[0] && n < 10) begin @(negedge clk); n++; end
        len1 = 0;
        while (busy_v[0] && len1 < 6000) begin
            if (len1 >= 1000 && len1 < 1200) ready_v[0] = 1'($urandom_range(0, 1));
            else ready_v[0] = 1'b1;
            len1++;
            @(negedge clk);
        end
        gap = 0;
        while (!busy_v[0] && gap < 10) begin gap++; @(negedge clk); end
        ready_v[0] = 1'b0;
        len2 = 0;
        while (busy_v[0] && len2 < 6000) begin len2++; @(negedge clk); end
        checks++;
        if (len1 !== 5120) begin failures++; $display("FAIL held_run1_len got=%0d exp=5120", len1); end
        checks++;
        if (gap !== 1) begin failures++; $display("FAIL held_gap got=%0d exp=1", gap); end
        checks++;
        if (len2 !== 5120) begin failures++; $display("FAIL held_run2_len got=%0d exp=5120", len2); end
        checks++;
        if (wr_cnt[0] !== 2048 || count_mismatch(0) !== 0) begin
            failures++;
            $display("FAIL held_model got_writes=%0d got_mismatches=%0d exp 2048/0", wr_cnt[0], count_mismatch(0));
        end
    endtask

    task automatic test_no_overlap();
        checks++;
        if (overlap !== 0) begin failures++; $display("FAIL rd_wr_overlap got=%0d exp=0", overlap); end
    endtask

    initial begin
        ready_v = '0;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin bcnt[k] = 0; wr_cnt[k] = 0; last_wr[k] = -1; end
        test_reset();
        test_ramp();
        test_relu_saturate();
        test_round_negative();
        test_reset_midrun();
        test_pool4();
        test_ready_held();
        test_no_overlap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
